// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// constants, ALU op selects and datapath mux encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_REXEC,
        S_RWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BEQ,
        S_IEXEC,
        S_IWB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Encoding 3 is reserved and never driven.
    typedef enum logic [2:0] {
        ALU_AND  = 3'd0,
        ALU_OR   = 3'd1,
        ALU_ADD  = 3'd2,
        ALU_ANDN = 3'd4,
        ALU_ORN  = 3'd5,
        ALU_SUB  = 3'd6,
        ALU_SLT  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_B       = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } src_b_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct decoder: maps funct to an ALU op select and flags unsupported functs.
module mips_alu_dec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output alu_op_t    alu_sel,
    output logic       illegal
);

    always_comb begin
        alu_sel = ALU_AND;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_sel = ALU_ADD;
            FN_SUB:  alu_sel = ALU_SUB;
            FN_AND:  alu_sel = ALU_AND;
            FN_OR:   alu_sel = ALU_OR;
            FN_SLT:  alu_sel = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and handshakes with a shared, stallable instruction/data memory.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter  int unsigned ADDR_W   = 32,
    localparam int unsigned PC_SEL_W = (ADDR_W >= 2) ? $bits(pc_src_t) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_write,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_en,
    output logic [PC_SEL_W-1:0] pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [2:0]          alu_sel,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                illegal_op
);

    state_t  state, state_nxt;
    alu_op_t alu_op, dec_op;
    src_b_t  src_b;
    pc_src_t pc_sel;
    logic    pc_write, branch, dec_illegal;

    mips_alu_dec u_alu_dec (
        .funct   (funct),
        .alu_sel (dec_op),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_sel     = PC_ALU;
        alu_src_a  = 1'b0;
        src_b      = SRCB_B;
        alu_op     = ALU_AND;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                src_b   = SRCB_FOUR;
                alu_op  = ALU_ADD;
                // IR/PC update only in the cycle the memory accepts the read.
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                src_b  = SRCB_IMM_SH2;
                alu_op = ALU_ADD;
                case (opcode)
                    OP_RTYPE:     state_nxt = S_REXEC;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_ADDI:      state_nxt = S_IEXEC;
                    OP_J:         state_nxt = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                endcase
            end
            S_REXEC: begin
                alu_src_a = 1'b1;
                alu_op    = dec_op;
                if (dec_illegal) begin
                    illegal_op = 1'b1;
                    state_nxt  = S_FETCH;
                end else begin
                    state_nxt = S_RWB;
                end
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                src_b     = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                branch    = 1'b1;
                pc_sel    = PC_ALUOUT;
                state_nxt = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                src_b     = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_nxt = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                pc_sel    = PC_JUMP;
                pc_write  = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign pc_en     = pc_write | (branch & alu_zero);
    assign pc_src    = PC_SEL_W'(pc_sel);
    assign alu_src_b = src_b;
    assign alu_sel   = alu_op;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: stimulus pushes hand-computed per-cycle output
// vectors, a negedge monitor pops and compares them against the DUT.
module tb_mips_mc_ctrl;

    logic       clk, rst_n;
    logic [5:0] opcode, funct;
    logic       alu_zero, mem_ready;
    logic       mem_req, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a;
    logic [2:0] alu_sel;
    logic       reg_dst, mem_to_reg, reg_write, illegal_op;

    typedef struct {
        logic [16:0] v;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mips_mc_ctrl #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_sel    (alu_sel),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal_op (illegal_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Field order: req wr iord irw pcen pcsrc srca srcb sel rdst m2r rw ill
    function automatic logic [16:0] mk(int req, int wr, int io, int irw, int pce, int pcs,
                                       int sa, int sbv, int sel, int rd, int m2r, int rw, int ill);
        return {1'(req), 1'(wr), 1'(io), 1'(irw), 1'(pce), 2'(pcs), 1'(sa), 2'(sbv),
                3'(sel), 1'(rd), 1'(m2r), 1'(rw), 1'(ill)};
    endfunction

    function automatic logic [16:0] e_fetch(int rdy);
        return mk(1, 0, 0, rdy, rdy, 0, 0, 1, 2, 0, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_decode(int ill);
        return mk(0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0, 0, ill);
    endfunction
    function automatic logic [16:0] e_rexec(int sel, int ill);
        return mk(0, 0, 0, 0, 0, 0, 1, 0, sel, 0, 0, 0, ill);
    endfunction
    function automatic logic [16:0] e_beq(int z);
        return mk(0, 0, 0, 0, z, 1, 1, 0, 6, 0, 0, 0, 0);
    endfunction

    localparam logic [16:0] E_ZERO   = 17'd0;
    localparam logic [16:0] E_RWB    = 17'b0_0_0_0_0_00_0_00_000_1_0_1_0;
    localparam logic [16:0] E_MEMADR = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
    localparam logic [16:0] E_MEMRD  = 17'b1_0_1_0_0_00_0_00_000_0_0_0_0;
    localparam logic [16:0] E_MEMWB  = 17'b0_0_0_0_0_00_0_00_000_0_1_1_0;
    localparam logic [16:0] E_MEMWR  = 17'b1_1_1_0_0_00_0_00_000_0_0_0_0;
    localparam logic [16:0] E_IEXEC  = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
    localparam logic [16:0] E_IWB    = 17'b0_0_0_0_0_00_0_00_000_0_0_1_0;
    localparam logic [16:0] E_JUMP   = 17'b0_0_0_0_1_10_0_00_000_0_0_0_0;

    task automatic cyc(input logic [16:0] v, input string name);
        exp_t e;
        e.v    = v;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic [16:0] act;
            e   = sb.pop_front();
            act = {mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                   alu_sel, reg_dst, mem_to_reg, reg_write, illegal_op};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %b expected %b (req wr iord irw pcen pcsrc srca srcb sel rdst m2r rw ill)",
                         e.name, act, e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'd0;
        funct     = 6'd0;
        alu_zero  = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cyc(E_ZERO, "reset_hold");
        rst_n = 1'b1;
        cyc(E_ZERO, "idle_after_reset");

        opcode = 6'b000000; funct = 6'b100000;
        cyc(e_fetch(1), "add_fetch");
        cyc(e_decode(0), "add_decode");
        cyc(e_rexec(2, 0), "add_rexec");
        cyc(E_RWB, "add_rwb");

        funct = 6'b101010;
        cyc(e_fetch(1), "slt_fetch");
        cyc(e_decode(0), "slt_decode");
        cyc(e_rexec(7, 0), "slt_rexec");
        cyc(E_RWB, "slt_rwb");

        opcode = 6'b100011; mem_ready = 1'b0;
        repeat (3) cyc(e_fetch(0), "lw_fetch_stall");
        mem_ready = 1'b1;
        cyc(e_fetch(1), "lw_fetch_ready");
        mem_ready = 1'b0;
        cyc(e_decode(0), "lw_decode_ready_ignored");
        cyc(E_MEMADR, "lw_memadr");
        repeat (2) cyc(E_MEMRD, "lw_memrd_stall");
        mem_ready = 1'b1;
        cyc(E_MEMRD, "lw_memrd_ready");
        cyc(E_MEMWB, "lw_memwb");

        opcode = 6'b101011;
        cyc(e_fetch(1), "sw_fetch");
        cyc(e_decode(0), "sw_decode");
        cyc(E_MEMADR, "sw_memadr");
        cyc(E_MEMWR, "sw_memwr");

        opcode = 6'b000100; alu_zero = 1'b1;
        cyc(e_fetch(1), "beq_t_fetch");
        cyc(e_decode(0), "beq_t_decode");
        cyc(e_beq(1), "beq_taken");
        alu_zero = 1'b0;
        cyc(e_fetch(1), "beq_nt_fetch");
        cyc(e_decode(0), "beq_nt_decode");
        cyc(e_beq(0), "beq_not_taken");

        opcode = 6'b001000;
        cyc(e_fetch(1), "addi_fetch");
        cyc(e_decode(0), "addi_decode");
        cyc(E_IEXEC, "addi_iexec");
        cyc(E_IWB, "addi_iwb");

        opcode = 6'b000010;
        cyc(e_fetch(1), "j_fetch");
        cyc(e_decode(0), "j_decode");
        cyc(E_JUMP, "j_jump");

        opcode = 6'b111111;
        cyc(e_fetch(1), "illop_fetch");
        cyc(e_decode(1), "illop_decode");

        opcode = 6'b000000; funct = 6'b000111;
        cyc(e_fetch(1), "illfn_fetch");
        cyc(e_decode(0), "illfn_decode");
        cyc(e_rexec(0, 1), "illfn_rexec");

        opcode = 6'b101011; funct = 6'b000000;
        cyc(e_fetch(1), "rst_sw_fetch");
        cyc(e_decode(0), "rst_sw_decode");
        cyc(E_MEMADR, "rst_sw_memadr");
        mem_ready = 1'b0;
        cyc(E_MEMWR, "rst_sw_memwr_stall");
        rst_n = 1'b0;
        cyc(E_ZERO, "rst_mid_memwr");
        cyc(E_ZERO, "rst_mid_hold");
        rst_n = 1'b1; mem_ready = 1'b1;
        cyc(E_ZERO, "restart_idle");
        cyc(e_fetch(1), "restart_fetch");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
